// File: rtl/display_pkg.sv
// Shared defaults, scan state type and address-width helper for the scrolling display controller.
package display_pkg;

  localparam int unsigned DefNumDigits   = 4;
  localparam int unsigned DefCharW       = 4;
  localparam int unsigned DefMsgLen      = 16;
  localparam int unsigned DefDwellCycles = 16;
  localparam int unsigned DefBlankCycles = 2;
  localparam int unsigned DefScrollFrames = 4;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  // Width needed to index 0..len-1; never less than one bit.
  function automatic int unsigned addr_w(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a falling-edge pulse detector.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic fell
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
    end
  end

  assign fell = prev_q & ~sync_q[1];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Multiplexed scrolling character display: per-digit blank/on scan, message buffer and
// frame-aligned window advance from button presses and an auto-scroll timer.
module scroll_display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = DefNumDigits,
  parameter int unsigned CHAR_W        = DefCharW,
  parameter int unsigned MSG_LEN       = DefMsgLen,
  parameter int unsigned DWELL_CYCLES  = DefDwellCycles,
  parameter int unsigned BLANK_CYCLES  = DefBlankCycles,
  parameter int unsigned SCROLL_FRAMES = DefScrollFrames,
  localparam int unsigned AW           = addr_w(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nxt_button,
  input  logic                  auto_en,
  input  logic                  step_mode,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [CHAR_W-1:0]     char,
  output logic [AW-1:0]         msg_index,
  output logic                  frame_start
);

  localparam int unsigned SlotW = addr_w(DWELL_CYCLES);
  localparam int unsigned DigW  = addr_w(NUM_DIGITS);
  localparam int unsigned FrmW  = addr_w(SCROLL_FRAMES);
  localparam int unsigned SumW  = AW + 1;

  scan_state_e      state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [DigW-1:0]  dig_q, dig_d;

  logic             last_slot_cycle;
  logic             frame_end;
  logic             load_char;

  logic [CHAR_W-1:0] msg_buf_q [MSG_LEN];
  logic [CHAR_W-1:0] char_q;
  logic [AW-1:0]     idx_q, idx_d;
  logic [FrmW-1:0]   auto_cnt_q, auto_cnt_d;
  logic              pending_q, pending_d;

  logic              btn_fell;
  logic              auto_req;
  logic              advance;
  logic [SumW-1:0]   rd_sum, step_sum;
  logic [AW-1:0]     rd_addr;
  logic [CHAR_W-1:0] rd_char;

  btn_sync_edge u_btn_sync_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (nxt_button),
    .fell  (btn_fell)
  );

  // Scan FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK;
      slot_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      dig_q   <= dig_d;
    end
  end

  assign last_slot_cycle = (slot_q == SlotW'(DWELL_CYCLES - 1));
  assign frame_end       = (state_q == ON) && last_slot_cycle &&
                           (dig_q == DigW'(NUM_DIGITS - 1));

  // Scan FSM: next state. The slot counter spans both states of one digit slot.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + SlotW'(1);
    dig_d   = dig_q;
    unique case (state_q)
      BLANK: begin
        if (slot_q == SlotW'(BLANK_CYCLES - 1)) state_d = ON;
      end
      ON: begin
        if (last_slot_cycle) begin
          state_d = BLANK;
          slot_d  = '0;
          dig_d   = (dig_q == DigW'(NUM_DIGITS - 1)) ? '0 : dig_q + DigW'(1);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Scan FSM: outputs. an[NUM_DIGITS-1] is the leftmost digit (d = 0).
  always_comb begin
    an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_q == ON) && (dig_q == DigW'(NUM_DIGITS - 1 - i))) an[i] = 1'b0;
    end
    load_char   = (state_q == BLANK) && (slot_q == '0);
    frame_start = reset && load_char && (dig_q == '0);
  end

  // Window address and index advance, wrapped by compare-and-subtract.
  always_comb begin
    rd_sum  = {1'b0, idx_q} + SumW'(dig_q);
    rd_addr = (rd_sum >= SumW'(MSG_LEN)) ? AW'(rd_sum - SumW'(MSG_LEN)) : AW'(rd_sum);
    rd_char = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (rd_addr == AW'(i)) rd_char = msg_buf_q[i];
    end

    step_sum = {1'b0, idx_q} + (step_mode ? SumW'(NUM_DIGITS) : SumW'(1));
    auto_req = frame_end && auto_en && (auto_cnt_q == FrmW'(SCROLL_FRAMES - 1));
    advance  = frame_end && (pending_q || auto_req);

    idx_d = idx_q;
    if (advance) begin
      idx_d = (step_sum >= SumW'(MSG_LEN)) ? AW'(step_sum - SumW'(MSG_LEN)) : AW'(step_sum);
    end

    auto_cnt_d = auto_cnt_q;
    if (!auto_en) auto_cnt_d = '0;
    else if (frame_end) auto_cnt_d = auto_req ? '0 : auto_cnt_q + FrmW'(1);

    // A press detected on the boundary cycle itself carries into the next frame.
    pending_d = frame_end ? btn_fell : (pending_q | btn_fell);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_q     <= '0;
      idx_q      <= '0;
      auto_cnt_q <= '0;
      pending_q  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) msg_buf_q[i] <= CHAR_W'(i);
    end else begin
      if (load_char) char_q <= rd_char;
      idx_q      <= idx_d;
      auto_cnt_q <= auto_cnt_d;
      pending_q  <= pending_d;
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_en && (wr_addr == AW'(i))) msg_buf_q[i] <= wr_data;
      end
    end
  end

  assign char      = char_q;
  assign msg_index = idx_q;

endmodule

// File: doc/scroll_display_ctrl.md
SCROLL_DISPLAY_CTRL -- requirements
Module: scroll_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; must be at least 1.
REQ-002 Parameter CHAR_W, default 4: width of one character code.
REQ-003 Parameter MSG_LEN, default 16: message buffer depth; must be at least NUM_DIGITS; need not be a power of 2.
REQ-004 Parameter DWELL_CYCLES, default 16: clocks per digit slot; must exceed BLANK_CYCLES.
REQ-005 Parameter BLANK_CYCLES, default 2: all-anodes-off clocks at the start of each slot (anti-ghosting); must be at least 1.
REQ-006 Parameter SCROLL_FRAMES, default 4: frames per auto-scroll step; must be at least 1.
REQ-007 Port clk, input, 1: the single clock; it drives all state.
REQ-008 Port reset, input, 1: asynchronous, active-low reset.
REQ-009 Port nxt_button, input, 1: asynchronous; a falling edge is one press.
REQ-010 Port auto_en, input, 1: enables auto-scroll.
REQ-011 Port step_mode, input, 1: 0 advances the index by 1 character; 1 advances it by NUM_DIGITS.
REQ-012 Port wr_en, input, 1: write strobe for the message buffer.
REQ-013 Port wr_addr, input, AW = clog2(MSG_LEN): write address; writes with wr_addr at or above MSG_LEN are ignored.
REQ-014 Port wr_data, input, CHAR_W: write data.
REQ-015 Port an, output, NUM_DIGITS: active-low one-hot anodes; an[NUM_DIGITS-1] is the leftmost digit.
REQ-016 Port char, output, CHAR_W: code of the character for the lit digit.
REQ-017 Port msg_index, output, AW: current start index of the window.
REQ-018 Port frame_start, output, 1: one-cycle pulse on cycle 0 of slot 0.

Function
REQ-019 Scan FSM SHALL have states BLANK and ON, a slot counter and a digit counter d (0..NUM_DIGITS-1); d=0 is the leftmost digit.
- Each slot SHALL last DWELL_CYCLES clocks: BLANK_CYCLES clocks in BLANK, then ON for the rest.
REQ-020 In BLANK, an SHALL be all ones, and char SHALL load message[(msg_index+d) mod MSG_LEN] on the first BLANK cycle.
REQ-021 In ON, exactly an[NUM_DIGITS-1-d] SHALL be 0, with char stable for the whole state.
REQ-022 After the last ON cycle of digit d, the FSM SHALL enter BLANK for digit (d+1) mod NUM_DIGITS.
- One frame = NUM_DIGITS*DWELL_CYCLES clocks.
REQ-023 msg_index SHALL change only on cycle 0 of slot 0 (frame boundary), so no frame is ever torn.
REQ-024 nxt_button SHALL pass through a 2-flop synchroniser, then a falling-edge detector; each detected edge SHALL set a pending flag.
- Multiple edges within one frame SHALL coalesce into a single pending advance.
REQ-025 The auto-scroll frame counter SHALL run only while auto_en=1; on reaching SCROLL_FRAMES-1 at a frame boundary it SHALL request an advance and clear to 0.
- auto_en=0 SHALL clear the counter.
REQ-026 At a frame boundary with an advance requested (pending flag, auto request, or both), the FSM SHALL:
- set msg_index to (msg_index + step) mod MSG_LEN, where step = 1 or NUM_DIGITS according to step_mode sampled at that cycle;
- clear the pending flag;
- apply exactly one advance even when button and auto requests coincide.
REQ-027 The wrap-around SHALL use compare-and-subtract, never a power-of-2 truncation.
REQ-028 A write SHALL update the buffer on the clock edge where wr_en=1.
- A write to the entry currently displayed SHALL appear at that digit's next BLANK load, not mid-slot.
REQ-029 A button edge arriving on the same cycle as a frame boundary SHALL be retained for the next frame, not lost.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force:
- an = all ones, char = 0, msg_index = 0, frame_start = 0;
- FSM = BLANK, d = 0, slot counter = 0;
- pending flag = 0, auto counter = 0, synchroniser flops = 1;
- buffer entry i = i mod 2^CHAR_W.
REQ-031 A reset asserted mid-frame SHALL abandon the frame; after release the first cycle SHALL be cycle 0 of slot 0, with frame_start=1.

Structure
REQ-032 Package display_pkg SHALL hold the default parameter values, the scan state enum (BLANK, ON) and the AW width function.
REQ-033 Sub-module btn_sync_edge (synchroniser plus falling-edge pulse) SHALL be the only sub-module.

Verification (defaults)
REQ-034 Release reset, idle inputs -> an=1111 on cycles 0-1; an=0111, char=0 on cycles 2-15; an=1011, char=1 on cycles 18-31; frame_start at cycles 0, 64, 128.
REQ-035 One button press mid-frame 0, step_mode=0 -> msg_index=1 at cycle 64; the leftmost digit shows 1.
- Three presses in one frame -> msg_index=1 only.
REQ-036 auto_en=1, step_mode=1 -> msg_index goes 4, 8, 12, 0 at cycles 256, 512, 768, 1024 (wrap).
- Repeat with MSG_LEN=10 -> 4, 8, 2.
REQ-037 Button edge plus auto request at the same frame boundary -> msg_index advances once; a press landing exactly on the boundary advances on the following frame.
REQ-038 Write wr_addr=1, wr_data=9 while digit 1 is ON -> char stays 1 until that slot ends; char=9 in the next frame's digit-1 slot.
REQ-039 Assert reset at cycle 40 of a frame -> an=1111 immediately; after release, the timing of REQ-034 repeats exactly.
